codec_audio_out: RTL and testbench

- Drives a WM8731-class stereo audio CODEC from two 16-bit signed PCM samples.
- Generates the CODEC master clock (aud_xck), bit clock and DAC LR clock.
- Serialises samples in I2S format, with optional channel swap and centred cross-mix.
- Configures the CODEC once after reset over a write-only I2C link.
- Sits between the core's DAC sample outputs and the board CODEC pins.

---
 rtl/codec_audio_pkg.sv | 38 +++
 rtl/codec_audio_out_if.sv | 17 +
 rtl/codec_i2c_cfg.sv | 126 ++++++++++++
 rtl/codec_audio_out.sv | 90 +++++++++
 tb/tb_codec_audio_out.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/codec_audio_pkg.sv
// -----------------------------------------------------------------------------
// codec_audio_pkg
// Shared constants for the WM8731 audio output path: default I2C address,
// the power-up register write table, frame length, the I2C sequencer state
// type and the centred cross-mix helper.
// -----------------------------------------------------------------------------
package codec_audio_pkg;

   localparam logic [7:0] I2C_ADDR_DEF = 8'h34;
   localparam int         FRAME_BITS   = 32;

   // Register reset, then R0..R9 in ascending order; R9 (active) goes last so
   // the CODEC only starts once fully configured.
   localparam int NUM_WORDS = 11;
   localparam logic [15:0] INIT_WORDS [NUM_WORDS] = '{
      16'h1E00, 16'h0080, 16'h0280, 16'h0479, 16'h0679, 16'h0810,
      16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201
   };

   typedef enum logic [2:0] {
      I2C_IDLE,    // 4-quarter bus-idle gap before each START
      I2C_START,
      I2C_DATA,    // 3 bytes x 9 clocks (8 data + released ACK slot)
      I2C_STOP,
      I2C_DONE
   } i2c_state_e;

   // (3a+b)>>>2 in 18-bit signed; taking bits [17:2] is the shift plus the
   // truncation to 16 bits in one step.
   function automatic logic [15:0] mix_word(input logic [15:0] a, input logic [15:0] b);
      logic signed [17:0] sa, sb, s;
      sa = {{2{a[15]}}, a};
      sb = {{2{b[15]}}, b};
      s  = sa + sa + sa + sb;
      return s[17:2];
   endfunction

endpackage

// File: rtl/codec_audio_out_if.sv
// -----------------------------------------------------------------------------
// codec_audio_out_if
// PCM sample bus from the core to the audio output block.
//   ldata/rdata : 16-bit signed left/right samples
//   exchan      : 1 = swap channels before mixing
//   mix         : 1 = centred cross-mix, 0 = pass-through
// master = sample source, slave = codec_audio_out.
// -----------------------------------------------------------------------------
interface codec_audio_out_if;
   logic [15:0] ldata;
   logic [15:0] rdata;
   logic        exchan;
   logic        mix;

   modport master (output ldata, rdata, exchan, mix);
   modport slave  (input  ldata, rdata, exchan, mix);
endinterface

// File: rtl/codec_i2c_cfg.sv
// -----------------------------------------------------------------------------
// codec_i2c_cfg
// Write-only I2C master that pushes INIT_WORDS to the CODEC once after reset,
// then parks the bus idle forever. ACKs are not sampled.
//   clk, rst : system clock, async active-high reset
//   o_sclk   : SCL, push-pull
//   io_sdat  : SDA, open-drain (drives 0 or Z)
// Each bit slot is 4 quarter-bit phases of I2C_DIV clocks; SDA only moves
// while SCL is low, except the SDA edges that form START/STOP.
// -----------------------------------------------------------------------------
module codec_i2c_cfg
   import codec_audio_pkg::*;
#(
   parameter int         I2C_DIV  = 140,
   parameter logic [7:0] I2C_ADDR = I2C_ADDR_DEF
)(
   input  logic clk,
   input  logic rst,
   output logic o_sclk,
   inout  wire  io_sdat
);

   localparam int QW = (I2C_DIV > 1) ? $clog2(I2C_DIV) : 1;

   i2c_state_e    r_state, w_state_nxt;
   logic [QW-1:0] r_qdiv;
   logic [1:0]    r_q;       // quarter within the current bit slot
   logic [3:0]    r_pos;     // 0..7 data bits, 8 = ACK slot
   logic [1:0]    r_byte;    // 0 = address, 1 = hi, 2 = lo
   logic [3:0]    r_word;
   logic          r_scl, r_sda_low;
   logic          w_tick, w_slot_end, w_last_bit, w_scl, w_sda;
   logic [7:0]    w_byte;

   assign w_tick     = (r_qdiv == QW'(I2C_DIV - 1));
   assign w_slot_end = w_tick && (r_q == 2'd3);
   assign w_last_bit = (r_pos == 4'd8) && (r_byte == 2'd2);

   always_comb begin
      w_byte = I2C_ADDR;
      case (r_byte)
         2'd1:    w_byte = INIT_WORDS[r_word][15:8];
         2'd2:    w_byte = INIT_WORDS[r_word][7:0];
         default: w_byte = I2C_ADDR;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= I2C_IDLE;
      else     r_state <= w_state_nxt;
   end

   // next state: transitions only at the end of a bit slot
   always_comb begin
      w_state_nxt = r_state;
      if (w_slot_end) begin
         case (r_state)
            I2C_IDLE:  w_state_nxt = I2C_START;
            I2C_START: w_state_nxt = I2C_DATA;
            I2C_DATA:  if (w_last_bit) w_state_nxt = I2C_STOP;
            I2C_STOP:  w_state_nxt = (r_word == 4'(NUM_WORDS - 1)) ? I2C_DONE : I2C_IDLE;
            default:   w_state_nxt = I2C_DONE;
         endcase
      end
   end

   // outputs per state/quarter
   always_comb begin
      w_scl = 1'b1;
      w_sda = 1'b1;
      case (r_state)
         I2C_START: begin
            w_scl = (r_q != 2'd3);
            w_sda = (r_q == 2'd0);          // SDA falls in q1 with SCL high
         end
         I2C_DATA: begin
            w_scl = (r_q == 2'd1) || (r_q == 2'd2);
            w_sda = (r_pos == 4'd8) || w_byte[~r_pos[2:0]];
         end
         I2C_STOP: begin
            w_scl = (r_q != 2'd0);
            w_sda = r_q[1];                 // SDA rises in q2 with SCL high
         end
         default: ;
      endcase
   end

   // quarter divider and bit/byte/word counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_qdiv <= '0;
         r_q    <= '0;
         r_pos  <= '0;
         r_byte <= '0;
         r_word <= '0;
      end else if (r_state != I2C_DONE) begin
         r_qdiv <= w_tick ? '0 : r_qdiv + 1'b1;
         if (w_tick) r_q <= r_q + 2'd1;
         if (w_slot_end && r_state == I2C_DATA) begin
            if (r_pos == 4'd8) begin
               r_pos  <= '0;
               r_byte <= (r_byte == 2'd2) ? 2'd0 : r_byte + 2'd1;
            end else begin
               r_pos <= r_pos + 4'd1;
            end
         end
         if (w_slot_end && r_state == I2C_STOP) r_word <= r_word + 4'd1;
      end
   end

   // registered pins so SCL/SDA never glitch on decode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl     <= 1'b1;
         r_sda_low <= 1'b0;
      end else begin
         r_scl     <= w_scl;
         r_sda_low <= ~w_sda;
      end
   end

   assign o_sclk  = r_scl;
   assign io_sdat = r_sda_low ? 1'b0 : 1'bz;

endmodule

// File: rtl/codec_audio_out.sv
// -----------------------------------------------------------------------------
// codec_audio_out
// I2S output to a WM8731-class CODEC plus one-shot I2C configuration.
//   clk, rst      : system clock, async active-high reset
//   s_pcm         : sample bus (ldata, rdata, exchan, mix)
//   o_aud_xck     : CODEC master clock, clk/2
//   o_aud_bclk    : bit clock, clk/(2*BCLK_DIV)
//   o_aud_daclrck : 0 = left word, 1 = right word
//   o_aud_dacdat  : serial data, MSB first, one-bclk I2S delay
//   o_i2c_sclk    : I2C clock
//   io_i2c_sdat   : I2C data, open-drain
// -----------------------------------------------------------------------------
module codec_audio_out
   import codec_audio_pkg::*;
#(
   parameter int         BCLK_DIV = 8,
   parameter int         I2C_DIV  = 140,
   parameter logic [7:0] I2C_ADDR = I2C_ADDR_DEF
)(
   input  logic             clk,
   input  logic             rst,
   codec_audio_out_if.slave s_pcm,
   output logic             o_aud_xck,
   output logic             o_aud_bclk,
   output logic             o_aud_daclrck,
   output logic             o_aud_dacdat,
   output logic             o_i2c_sclk,
   inout  wire              io_i2c_sdat
);

   localparam int BW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

   logic [BW-1:0] r_bdiv;
   logic          r_xck, r_bclk, r_dat;
   logic [4:0]    r_bitcnt;
   logic [15:0]   r_lsmp, r_rsmp;
   logic          w_bwrap, w_bfall;
   logic [15:0]   w_a, w_b, w_l, w_r;

   assign w_bwrap = (r_bdiv == BW'(BCLK_DIV - 1));
   assign w_bfall = w_bwrap && r_bclk;

   assign w_a = s_pcm.exchan ? s_pcm.rdata : s_pcm.ldata;
   assign w_b = s_pcm.exchan ? s_pcm.ldata : s_pcm.rdata;
   assign w_l = s_pcm.mix ? mix_word(w_a, w_b) : w_a;
   assign w_r = s_pcm.mix ? mix_word(w_b, w_a) : w_b;

   // The bit sent after a falling edge belongs to the slot *before* the new
   // counter value (I2S one-bit delay), i.e. to the current r_bitcnt. At the
   // 31->0 wrap this sends the old right LSB while the new samples latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_xck    <= 1'b0;
         r_bdiv   <= '0;
         r_bclk   <= 1'b0;
         r_bitcnt <= '0;
         r_dat    <= 1'b0;
         r_lsmp   <= '0;
         r_rsmp   <= '0;
      end else begin
         r_xck  <= ~r_xck;
         r_bdiv <= w_bwrap ? '0 : r_bdiv + 1'b1;
         if (w_bwrap) r_bclk <= ~r_bclk;
         if (w_bfall) begin
            r_bitcnt <= r_bitcnt + 5'd1;
            r_dat    <= r_bitcnt[4] ? r_rsmp[~r_bitcnt[3:0]] : r_lsmp[~r_bitcnt[3:0]];
            if (r_bitcnt == 5'(FRAME_BITS - 1)) begin
               r_lsmp <= w_l;
               r_rsmp <= w_r;
            end
         end
      end
   end

   assign o_aud_xck     = r_xck;
   assign o_aud_bclk    = r_bclk;
   assign o_aud_daclrck = r_bitcnt[4];
   assign o_aud_dacdat  = r_dat;

   codec_i2c_cfg #(
      .I2C_DIV  (I2C_DIV),
      .I2C_ADDR (I2C_ADDR)
   ) u_cfg (
      .clk     (clk),
      .rst     (rst),
      .o_sclk  (o_i2c_sclk),
      .io_sdat (io_i2c_sdat)
   );

endmodule

// File: tb/tb_codec_audio_out.sv
module tb_codec_audio_out;

   localparam int BCLK_DIV = 8;
   localparam int I2C_DIV  = 4;
   localparam int NW       = 11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic xck, bclk, lrck, dat, sclk;
   wire  sdat;
   pullup (sdat);

   codec_audio_out_if pcm ();

   codec_audio_out #(.BCLK_DIV(BCLK_DIV), .I2C_DIV(I2C_DIV), .I2C_ADDR(8'h34)) dut (
      .clk(clk), .rst(rst), .s_pcm(pcm),
      .o_aud_xck(xck), .o_aud_bclk(bclk), .o_aud_daclrck(lrck), .o_aud_dacdat(dat),
      .o_i2c_sclk(sclk), .io_i2c_sdat(sdat)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s timed out", name);
   endtask

   // ---------------- expected-value model ----------------
   function automatic int fdiv4(input int x);
      return (x >= 0) ? x / 4 : -((-x + 3) / 4);
   endfunction

   function automatic logic [31:0] ref_out(input logic [15:0] l, input logic [15:0] r,
                                           input bit ex, input bit mx);
      int a, b, lo, ro;
      a = $signed(ex ? r : l);
      b = $signed(ex ? l : r);
      if (mx) begin
         lo = fdiv4(3 * a + b);
         ro = fdiv4(3 * b + a);
      end else begin
         lo = a;
         ro = b;
      end
      return {lo[15:0], ro[15:0]};
   endfunction

   // ---------------- I2S receiver ----------------
   logic [15:0] cap_l, cap_r, hold_l, sh;
   logic        prev_lr;
   int          n_frames = 0;

   initial begin
      prev_lr = 1'b0;
      sh = '0;
      forever begin
         @(posedge bclk or posedge rst);
         #1;
         if (rst) begin
            prev_lr = 1'b0;
            sh = '0;
         end else if (lrck != prev_lr) begin
            // first bit after an LR change is the LSB of the previous word
            if (prev_lr) begin
               cap_l = hold_l;
               cap_r = {sh[14:0], dat};
               n_frames++;
            end else begin
               hold_l = {sh[14:0], dat};
            end
            sh = '0;
            prev_lr = lrck;
         end else begin
            sh = {sh[14:0], dat};
         end
      end
   end

   // ---------------- I2C bus decoder (never ACKs) ----------------
   logic [7:0]  cur_b[$];
   logic [23:0] txns[$];
   int          n_starts = 0;
   int          bad_len = 0;
   int          ack_low = 0;

   initial begin
      logic pscl, psda, s, d;
      logic [7:0] shb;
      int bitn;
      pscl = 1'b1; psda = 1'b1; bitn = 0; shb = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pscl = 1'b1; psda = 1'b1; bitn = 0;
            cur_b.delete();
         end else begin
            s = sclk;
            d = sdat;
            if (pscl && s && psda && !d) begin
               n_starts++;
               bitn = 0;
               cur_b.delete();
            end else if (pscl && s && !psda && d) begin
               if (cur_b.size() == 3) txns.push_back({cur_b[0], cur_b[1], cur_b[2]});
               else bad_len++;
            end else if (!pscl && s) begin
               if (bitn % 9 == 8) begin
                  if (!d) ack_low++;
               end else begin
                  shb = {shb[6:0], d};
                  if (bitn % 9 == 7) cur_b.push_back(shb);
               end
               bitn++;
            end
            pscl = s;
            psda = d;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_frames(input int k);
      int tgt;
      tgt = n_frames + k;
      for (int i = 0; i < k * 700 + 100 && n_frames < tgt; i++) @(negedge clk);
      if (n_frames < tgt) timeout("frame_wait");
   endtask

   task automatic measure_period(input bit use_lr, input int limit, output int period);
      logic p, c;
      int t0, edges;
      period = -1; edges = 0; t0 = 0;
      p = use_lr ? lrck : bclk;
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         c = use_lr ? lrck : bclk;
         if (c && !p) begin
            if (edges == 0) t0 = i;
            else begin
               period = i - t0;
               break;
            end
            edges++;
         end
         p = c;
      end
   endtask

   task automatic apply_and_check(input string name, input logic [15:0] l, input logic [15:0] r,
                                  input bit ex, input bit mx, input logic [31:0] exp);
      wait_frames(1);
      pcm.ldata = l; pcm.rdata = r; pcm.exchan = ex; pcm.mix = mx;
      wait_frames(2);
      chk({name, "_left"},  {16'h0, cap_l}, {16'h0, exp[31:16]});
      chk({name, "_right"}, {16'h0, cap_r}, {16'h0, exp[15:0]});
   endtask

   typedef struct {
      string       name;
      logic [15:0] l, r;
      bit          ex, mx;
      logic [15:0] el, er;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int p, bad, snap;
      logic prev;
      logic [15:0] rl, rr;
      bit rex, rmx;

      // -7FFF/8000 mixed: -65537 >>> 2 floors to -16385 = BFFF
      vecs[0] = '{"pass",     16'hA5A5, 16'h1234, 1'b0, 1'b0, 16'hA5A5, 16'h1234};
      vecs[1] = '{"swap",     16'hA5A5, 16'h1234, 1'b1, 1'b0, 16'h1234, 16'hA5A5};
      vecs[2] = '{"mix_ext",  16'h7FFF, 16'h8000, 1'b0, 1'b1, 16'h3FFF, 16'hBFFF};
      vecs[3] = '{"mix_fffc", 16'hFFFC, 16'hFFFC, 1'b0, 1'b1, 16'hFFFC, 16'hFFFC};
      vecs[4] = '{"mix_min",  16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 16'h8000};
      vecs[5] = '{"mix_swap", 16'h7FFF, 16'h8000, 1'b1, 1'b1, 16'hBFFF, 16'h3FFF};
      vecs[6] = '{"mix_small",16'h0004, 16'h0000, 1'b0, 1'b1, 16'h0003, 16'h0001};

      pcm.ldata = '0; pcm.rdata = '0; pcm.exchan = 1'b0; pcm.mix = 1'b0;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_xck", {31'h0, xck}, 32'h0);
      chk("rst_bclk", {31'h0, bclk}, 32'h0);
      chk("rst_lrck", {31'h0, lrck}, 32'h0);
      chk("rst_dacdat", {31'h0, dat}, 32'h0);
      chk("rst_sclk", {31'h0, sclk}, 32'h1);
      chk("rst_sdat_released", {31'h0, sdat}, 32'h1);
      rst = 1'b0;

      bad = 0;
      prev = xck;
      repeat (20) begin
         @(negedge clk);
         if (xck == prev) bad++;
         prev = xck;
      end
      chk("xck_toggle_misses", bad, 0);
      measure_period(1'b0, 200, p);
      chk("bclk_period", p, 2 * BCLK_DIV);
      measure_period(1'b1, 2000, p);
      chk("lrck_period", p, 32 * 2 * BCLK_DIV);

      foreach (vecs[i])
         apply_and_check(vecs[i].name, vecs[i].l, vecs[i].r, vecs[i].ex, vecs[i].mx,
                         {vecs[i].el, vecs[i].er});

      // exchan changed mid-frame: the frame already latched is unaffected
      apply_and_check("pre_swap", 16'hA5A5, 16'h1234, 1'b0, 1'b0, 32'hA5A51234);
      repeat (200) @(negedge clk);
      pcm.exchan = 1'b1;
      wait_frames(1);
      chk("midframe_old_left", {16'h0, cap_l}, 32'h0000A5A5);
      wait_frames(1);
      chk("midframe_new_left", {16'h0, cap_l}, 32'h00001234);
      chk("midframe_new_right", {16'h0, cap_r}, 32'h0000A5A5);

      for (int i = 0; i < 8; i++) begin
         rl = 16'($urandom);
         rr = 16'($urandom);
         rex = 1'($urandom_range(0, 1));
         rmx = 1'($urandom_range(0, 1));
         apply_and_check($sformatf("rand%0d", i), rl, rr, rex, rmx, ref_out(rl, rr, rex, rmx));
      end

      // I2C configuration stream
      for (int i = 0; i < 30000 && txns.size() < NW; i++) @(negedge clk);
      if (txns.size() < NW) timeout("i2c_sequence");
      chk("i2c_txn_count", txns.size(), NW);
      for (int i = 0; i < NW && i < txns.size(); i++)
         chk($sformatf("i2c_txn%0d", i), {8'h0, txns[i]},
             {8'h0, 8'h34, codec_audio_pkg::INIT_WORDS[i]});
      chk("i2c_bad_length", bad_len, 0);
      chk("i2c_ack_slot_driven", ack_low, 0);
      snap = n_starts;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (!(sclk === 1'b1 && sdat === 1'b1)) bad++;
      end
      chk("i2c_done_idle", bad, 0);
      chk("i2c_no_extra_start", n_starts, snap);

      // reset during the 4th configuration word
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      txns.delete(); n_starts = 0;
      rst = 1'b0;
      for (int i = 0; i < 10000 && n_starts < 4; i++) @(negedge clk);
      if (n_starts < 4) timeout("i2c_fourth_start");
      repeat (40) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_sclk", {31'h0, sclk}, 32'h1);
      chk("midrst_sdat", {31'h0, sdat}, 32'h1);
      chk("midrst_lrck", {31'h0, lrck}, 32'h0);
      repeat (3) @(negedge clk);
      txns.delete(); n_starts = 0;
      rst = 1'b0;
      p = -1;
      for (int i = 1; i <= 600; i++) begin
         @(posedge clk);
         #1;
         if (lrck) begin
            p = i;
            break;
         end
      end
      chk("lrck_restart_cycles", p, 16 * 2 * BCLK_DIV);
      for (int i = 0; i < 5000 && txns.size() < 1; i++) @(negedge clk);
      if (txns.size() < 1) timeout("i2c_restart");
      else chk("i2c_restart_word0", {8'h0, txns[0]}, 32'h00341E00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
